// File: rtl/rex_game_ctrl.sv
// Game-logic stage for the rex runner: rex jump physics, obstacle scroll,
// collision, score and game state. Everything advances on frame_tick only.
//   state | meaning
//   IDLE  | waiting for the first press, nothing moves
//   RUN   | physics, scroll and collision active
//   OVER  | positions frozen; restart accepted once hold reaches 0
module rex_game_ctrl #(
  parameter int SPAWN_X   = 256,
  parameter int SPEED     = 4,
  parameter int JUMP_V0   = 8,
  parameter int GRAVITY   = 1,
  parameter int REX_LEFT  = 8,
  parameter int REX_W     = 24,
  parameter int OBST_W    = 16,
  parameter int OBST_H    = 28,
  parameter int OVER_HOLD = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        frame_tick,
  input  logic        btn_jump,
  output logic [15:0] rex_down,
  output logic [15:0] obstacle_left,
  output logic [1:0]  game_state,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  localparam logic [15:0]        SPAWN_U     = 16'(SPAWN_X);
  localparam logic [15:0]        JUMP_U      = 16'(JUMP_V0);
  localparam logic signed [7:0]  VEL_LAUNCH  = 8'(JUMP_V0 - GRAVITY);
  localparam logic signed [7:0]  GRAVITY_V   = 8'(GRAVITY);
  localparam logic signed [16:0] SPEED_S     = 17'(SPEED);
  localparam logic signed [16:0] OBST_LIM_S  = 17'(-OBST_W);
  localparam logic signed [16:0] OBST_W_S    = 17'(OBST_W);
  localparam logic signed [16:0] REX_LEFT_S  = 17'(REX_LEFT);
  localparam logic signed [16:0] REX_RIGHT_S = 17'(REX_LEFT + REX_W);
  localparam logic signed [16:0] OBST_H_S    = 17'(OBST_H);
  localparam logic [15:0]        HOLD_U      = 16'(OVER_HOLD);

  logic              btn_s1_q, btn_s2_q, btn_s3_q;
  logic              pending_q, pending_d;
  logic [15:0]       rex_q, rex_d;
  logic signed [7:0] vel_q, vel_d;
  logic [15:0]       obst_q, obst_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       hold_q, hold_d;
  state_e            state_q, state_d;

  logic               edge_det, press, hit;
  logic signed [16:0] nd, nx, ox;

  always_comb begin
    edge_det  = btn_s2_q & ~btn_s3_q;
    press     = pending_q | edge_det;
    pending_d = frame_tick ? 1'b0 : press;
    rex_d     = rex_q;
    vel_d     = vel_q;
    obst_d    = obst_q;
    score_d   = score_q;
    hold_d    = hold_q;
    state_d   = state_q;
    nd        = 17'sd0;
    nx        = 17'sd0;
    ox        = 17'sd0;
    hit       = 1'b0;
    if (frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (press) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (rex_q == 16'd0 && vel_q == 8'sd0) begin
            if (press) begin
              rex_d = JUMP_U;
              vel_d = VEL_LAUNCH;
            end
          end else begin
            nd = $signed({1'b0, rex_q}) + $signed({{9{vel_q[7]}}, vel_q});
            if (nd <= 17'sd0) begin
              rex_d = 16'd0;
              vel_d = 8'sd0;
            end else begin
              rex_d = nd[15:0];
              vel_d = vel_q - GRAVITY_V;
            end
          end
          nx = $signed({obst_q[15], obst_q}) - SPEED_S;
          if (nx <= OBST_LIM_S) begin
            obst_d = SPAWN_U;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end else begin
            obst_d = nx[15:0];
          end
          // Collision is judged on the freshly computed positions.
          ox  = $signed({obst_d[15], obst_d});
          hit = (ox < REX_RIGHT_S) && ((ox + OBST_W_S) > REX_LEFT_S) &&
                ($signed({1'b0, rex_d}) < OBST_H_S);
          if (hit) begin
            state_d = ST_OVER;
            hold_d  = HOLD_U;
          end
        end
        ST_OVER: begin
          if (press && hold_q == 16'd0) begin
            rex_d   = 16'd0;
            vel_d   = 8'sd0;
            obst_d  = SPAWN_U;
            score_d = 16'd0;
            state_d = ST_RUN;
          end else if (hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Synchronizer resets high so a button held through reset yields no edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1_q  <= 1'b1;
      btn_s2_q  <= 1'b1;
      btn_s3_q  <= 1'b1;
      pending_q <= 1'b0;
      rex_q     <= 16'd0;
      vel_q     <= 8'sd0;
      obst_q    <= SPAWN_U;
      score_q   <= 16'd0;
      hold_q    <= 16'd0;
      state_q   <= ST_IDLE;
    end else begin
      btn_s1_q  <= btn_jump;
      btn_s2_q  <= btn_s1_q;
      btn_s3_q  <= btn_s2_q;
      pending_q <= pending_d;
      rex_q     <= rex_d;
      vel_q     <= vel_d;
      obst_q    <= obst_d;
      score_q   <= score_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
    end
  end

  assign rex_down      = rex_q;
  assign obstacle_left = obst_q;
  assign game_state    = state_q;
  assign score         = score_q;

endmodule
